// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter fed by a small byte FIFO.
// Bytes pushed on DMEM_transmit_request are queued and sent LSB first.
// A new frame starts the edge after a byte is queued. Frames go out
// back-to-back for as long as the FIFO holds data.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | line high, waiting for the FIFO to become non-empty
//   ST_START | start bit (line low) for CLKS_PER_BIT cycles
//   ST_DATA  | data bits 0..7 from shift_q[0], one per CLKS_PER_BIT cycles
//   ST_STOP  | stop bit (line high); the last cycle may chain into ST_START
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       SYS_clk,
    input  logic       SYS_reset,
    input  logic       DMEM_transmit_request,
    input  logic [7:0] DMEM_data_transmit,
    output logic       transmitter_buffer_full,
    output logic       uart_tx,
    output logic       transmitter_busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                tx_q, tx_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full_q, full_d;
    logic [7:0]          mem_q [FIFO_DEPTH];

    logic                push;
    logic                pop;
    logic                baud_last;
    logic                fifo_has_data;

    // A request is accepted purely on the pre-edge full flag, so a push that
    // coincides with a pop on a full FIFO is still dropped.
    assign push          = DMEM_transmit_request && !full_q;
    assign baud_last     = (bit_cnt_q == BAUD_LAST);
    assign fifo_has_data = (count_q != '0);

    // Frame sequencer: next state, baud/bit counters, shift register and the
    // registered line value for the state being entered.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (fifo_has_data) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    bit_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    bit_cnt_d = '0;
                    if (fifo_has_data) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // FIFO bookkeeping: pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        full_d  = (count_d == DEPTH_C);
    end

    // State and FIFO control registers with synchronous reset.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers are cleared.
    always_ff @(posedge SYS_clk) begin
        if (push && !SYS_reset) begin
            mem_q[wr_ptr_q] <= DMEM_data_transmit;
        end
    end

    assign uart_tx                 = tx_q;
    assign transmitter_buffer_full = full_q;
    assign transmitter_busy        = fifo_has_data || (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a frame-level reference model predicts the line,
// full and busy flags after every clock edge.
module tb_uart_transmitter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       SYS_clk = 1'b0;
    logic       SYS_reset = 1'b1;
    logic       req = 1'b0;
    logic [7:0] data = 8'h00;
    logic       full;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes, edge at which the transmitter is next free,
    // and the byte of the frame currently on the line.
    logic [7:0] mq[$];
    int         edge_n = 0;
    int         m_free = 0;
    logic [7:0] cur_byte = 8'h00;
    bit         last_accept = 0;

    always #5 SYS_clk = ~SYS_clk;

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .SYS_clk                 (SYS_clk),
        .SYS_reset               (SYS_reset),
        .DMEM_transmit_request   (req),
        .DMEM_data_transmit      (data),
        .transmitter_buffer_full (full),
        .uart_tx                 (tx),
        .transmitter_busy        (busy)
    );

    function automatic logic exp_line();
        int o;
        int k;
        if (edge_n < m_free) begin
            o = edge_n - (m_free - FRAME);
            k = o / CPB;
            if (k == 0) return 1'b0;
            if (k == 9) return 1'b1;
            return cur_byte[k-1];
        end
        return 1'b1;
    endfunction

    // One clock: drive inputs, advance the model at the edge, compare at negedge.
    task automatic tick(input logic rq, input logic [7:0] d, input logic rst);
        bit pre_full;
        bit do_pop;
        logic e_tx;
        logic e_full;
        logic e_busy;
        SYS_reset = rst;
        req       = rq;
        data      = d;
        @(posedge SYS_clk);
        edge_n++;
        if (rst) begin
            mq.delete();
            m_free      = edge_n;
            last_accept = 0;
        end else begin
            pre_full = (mq.size() == DEPTH);
            do_pop   = (mq.size() != 0) && (edge_n >= m_free);
            if (do_pop) begin
                cur_byte = mq.pop_front();
                m_free   = edge_n + FRAME;
            end
            last_accept = rq && !pre_full;
            if (last_accept) mq.push_back(d);
        end
        @(negedge SYS_clk);
        e_tx   = exp_line();
        e_full = (mq.size() == DEPTH);
        e_busy = (mq.size() != 0) || (edge_n < m_free);
        checks++;
        if (tx !== e_tx) begin
            errors++;
            $display("FAIL line edge %0d: got %b want %b", edge_n, tx, e_tx);
        end
        checks++;
        if (full !== e_full) begin
            errors++;
            $display("FAIL full edge %0d: got %b want %b", edge_n, full, e_full);
        end
        checks++;
        if (busy !== e_busy) begin
            errors++;
            $display("FAIL busy edge %0d: got %b want %b", edge_n, busy, e_busy);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (tx !== 1'b1 || full !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got tx=%b full=%b busy=%b want 1 0 0", tx, full, busy);
        end
        idle(50);
        checks++;
        if (tx !== 1'b1 || full !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: got tx=%b full=%b busy=%b want 1 0 0", tx, full, busy);
        end
    endtask

    task automatic test_single_byte();
        logic       s[FRAME];
        logic [9:0] pat;
        pat = 10'b1101001010;
        tick(1'b1, 8'hA5, 1'b0);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got tx=%b want 1 on push edge", tx);
        end
        for (int o = 0; o < FRAME; o++) begin
            tick(1'b0, 8'h00, 1'b0);
            s[o] = tx;
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (s[4*k+2] !== pat[k]) begin
                errors++;
                $display("FAIL single_bit%0d: got %b want %b", k, s[4*k+2], pat[k]);
            end
        end
        tick(1'b0, 8'h00, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i * 8'h11), 1'b0);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: got %b want 1", full);
        end
        tick(1'b1, 8'h66, 1'b0);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL fill_drop: got full=%b want 1", full);
        end
        idle(5 * FRAME + 10);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_push_on_pop();
        int guard;
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        guard = 0;
        while (edge_n + 1 < m_free && guard < 100) begin
            idle(1);
            guard++;
        end
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL pop_edge_prefull: got %b want 1", full);
        end
        tick(1'b1, 8'h77, 1'b0);
        checks++;
        if (full !== 1'b0) begin
            errors++;
            $display("FAIL pop_edge_after: got full=%b want 0", full);
        end
        tick(1'b1, 8'h77, 1'b0);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL pop_edge_retry: got full=%b want 1", full);
        end
        idle(5 * FRAME + 10);
    endtask

    task automatic test_reset_mid_frame();
        int ep;
        tick(1'b1, 8'hFF, 1'b0);
        ep = edge_n + 1;
        while (edge_n + 1 < ep + 18) idle(1);
        tick(1'b0, 8'h00, 1'b1);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL midreset: got tx=%b busy=%b full=%b want 1 0 0", tx, busy, full);
        end
        idle(5);
        tick(1'b1, 8'h3C, 1'b0);
        idle(FRAME + 5);
    endtask

    task automatic test_wrap();
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < 12 && guard < 2000) begin
            if (mq.size() < DEPTH) begin
                tick(1'b1, 8'(sent), 1'b0);
                if (last_accept) sent++;
            end else begin
                idle(1);
            end
            guard++;
        end
        checks++;
        if (guard >= 2000) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d bytes want 12", sent);
        end
        idle(5 * FRAME + 10);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1'b0);
        end
        idle(5 * FRAME + 10);
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill();
        test_push_on_pop();
        test_reset_mid_frame();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
